uart_rx: RTL and testbench

Serial receiver for the UART link: recovers 8N1 / 8E1 / 8O1 frames from the asynchronous RX line and presents each byte with a one-cycle VALID strobe plus parity and framing status. Sits at the pad-side of the UART block, opposite the transmitter, and shares its bit-period definition (BIT_TIME + 1 clocks per bit), LSB-first bit order and parity convention, so that a transmitter and a receiver with the same BIT_TIME interoperate directly.

---
 rtl/uart_rx.sv | 173 +++++++++++++++++
 tb/tb_uart_rx.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1/8E1/8O1 UART receiver with one-cycle VALID strobe plus parity and framing status.
// Define UART_RX_MAJORITY_EN to take each bit as the 2-of-3 majority around the bit centre.
module uart_rx #(
  parameter int unsigned BIT_TIME = 40
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       RX,
  input  logic       PARITY_EN,
  input  logic       PARITY_ODD,
  output logic [7:0] DATA,
  output logic       VALID,
  output logic       PARITY_ERR,
  output logic       FRAME_ERR,
  output logic       BUSY
);

  localparam logic [8:0] CntTerm = 9'(BIT_TIME);
  localparam logic [8:0] CntHalf = 9'(BIT_TIME / 2);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StBreak} state_e;

  state_e     state_q, state_d;
  logic       rx_meta_q, rx_s_q;
  logic [8:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shreg_q, shreg_d;
  logic [7:0] data_q, data_d;
  logic       par_q, par_d;
  logic       par_en_q, par_en_d;
  logic       perr_q, perr_d;
  logic       perr_out_q, perr_out_d;
  logic       ferr_q, ferr_d;
  logic       valid_q, valid_d;
  logic       stop_seen_q, stop_seen_d;
  logic       at_half;
  logic       bit_s;

  assign at_half = (cnt_q == CntHalf);

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] maj_q, maj_d;

  always_comb begin
    maj_d = maj_q;
    if (cnt_q == CntHalf - 9'd2) maj_d[0] = rx_s_q;
    if (cnt_q == CntHalf - 9'd1) maj_d[1] = rx_s_q;
    bit_s = (maj_q[0] & maj_q[1]) | (maj_q[0] & rx_s_q) | (maj_q[1] & rx_s_q);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) maj_q <= 2'b11;
    else          maj_q <= maj_d;
  end
`else
  assign bit_s = rx_s_q;
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    shreg_d     = shreg_q;
    data_d      = data_q;
    par_d       = par_q;
    par_en_d    = par_en_q;
    perr_d      = perr_q;
    perr_out_d  = perr_out_q;
    ferr_d      = ferr_q;
    valid_d     = 1'b0;
    stop_seen_d = stop_seen_q;

    unique case (state_q)
      StIdle: begin
        if (!rx_s_q) state_d = StStart;
      end
      StStart: begin
        if (at_half) begin
          if (!bit_s) begin
            state_d  = StData;
            par_en_d = PARITY_EN;
            // Seeding with the odd flag turns the XOR of data bits into the expected parity bit.
            par_d    = PARITY_ODD;
            idx_d    = 3'd0;
            perr_d   = 1'b0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StData: begin
        if (at_half) begin
          shreg_d = {bit_s, shreg_q[7:1]};
          par_d   = par_q ^ bit_s;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = par_en_q ? StParity : StStop;
        end
      end
      StParity: begin
        if (at_half) begin
          perr_d  = bit_s ^ par_q;
          state_d = StStop;
        end
      end
      StStop: begin
        if (at_half) begin
          data_d      = shreg_q;
          perr_out_d  = par_en_q & perr_q;
          ferr_d      = ~bit_s;
          valid_d     = 1'b1;
          stop_seen_d = 1'b1;
        end else if (stop_seen_q && (cnt_q == CntTerm)) begin
          // Leaving at the end of the stop period lets an immediate next start edge be caught.
          state_d     = ferr_q ? StBreak : StIdle;
          stop_seen_d = 1'b0;
        end
      end
      StBreak: begin
        if (rx_s_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Counter free-runs across the frame so every sample point stays one bit period apart.
    if ((state_q == StIdle) || (state_d == StIdle)) begin
      cnt_d = 9'd0;
    end else if (cnt_q == CntTerm) begin
      cnt_d = 9'd0;
    end else begin
      cnt_d = cnt_q + 9'd1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= StIdle;
      cnt_q       <= 9'd0;
      idx_q       <= 3'd0;
      shreg_q     <= 8'h00;
      data_q      <= 8'h00;
      par_q       <= 1'b0;
      par_en_q    <= 1'b0;
      perr_q      <= 1'b0;
      perr_out_q  <= 1'b0;
      ferr_q      <= 1'b0;
      valid_q     <= 1'b0;
      stop_seen_q <= 1'b0;
    end else begin
      rx_meta_q   <= RX;
      rx_s_q      <= rx_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shreg_q     <= shreg_d;
      data_q      <= data_d;
      par_q       <= par_d;
      par_en_q    <= par_en_d;
      perr_q      <= perr_d;
      perr_out_q  <= perr_out_d;
      ferr_q      <= ferr_d;
      valid_q     <= valid_d;
      stop_seen_q <= stop_seen_d;
    end
  end

  assign DATA       = data_q;
  assign VALID      = valid_q;
  assign PARITY_ERR = perr_out_q;
  assign FRAME_ERR  = ferr_q;
  assign BUSY       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: framing, parity, break, glitch, back-to-back and reset abort.
module tb_uart_rx;

  localparam int unsigned BitTime = 40;
  localparam int P = BitTime + 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic       par_en;
  logic       par_odd;
  logic [7:0] data;
  logic       valid;
  logic       perr;
  logic       ferr;
  logic       busy;

  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         vcnt = 0;
  int         vcyc = 0;
  int         fall_cyc = 0;
  int         busy_n;
  logic [7:0] vdata = 8'h00;
  logic       vperr = 1'b0;
  logic       vferr = 1'b0;
  logic       spk;

  always #5 clk = ~clk;

  uart_rx #(.BIT_TIME(BitTime)) u_dut (
    .CLK       (clk),
    .RESET_N   (rst_n),
    .RX        (rx),
    .PARITY_EN (par_en),
    .PARITY_ODD(par_odd),
    .DATA      (data),
    .VALID     (valid),
    .PARITY_ERR(perr),
    .FRAME_ERR (ferr),
    .BUSY      (busy)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin
      vcnt  = vcnt + 1;
      vcyc  = cyc;
      vdata = data;
      vperr = perr;
      vferr = ferr;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called on a negedge; drives start, data LSB first, optional parity, stop.
  task automatic send_frame(input logic [7:0] d, input logic pe, input logic pbit,
                            input logic stop, input logic spike);
    logic [10:0] bits;
    int n;
    if (pe) begin
      bits = {stop, pbit, d, 1'b0};
      n = 11;
    end else begin
      bits = {1'b0, stop, d, 1'b0};
      n = 10;
    end
    fall_cyc = cyc;
    for (int i = 0; i < n; i++) begin
      rx = bits[i];
      if (spike) begin
        repeat (20) @(negedge clk);
        rx = ~bits[i];
        @(negedge clk);
        rx = bits[i];
        repeat (P - 21) @(negedge clk);
      end else begin
        repeat (P) @(negedge clk);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rx = 1'b1; rst_n = 1'b0; par_en = 1'b0; par_odd = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_data", 32'(data), 32'h00);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_perr", 32'(perr), 32'd0);
    check("rst_ferr", 32'(ferr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);

    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
    check("a5_count", 32'(vcnt), 32'd1);
    check("a5_data", 32'(vdata), 32'hA5);
    check("a5_perr", 32'(vperr), 32'd0);
    check("a5_ferr", 32'(vferr), 32'd0);
    check("a5_latency", 32'(vcyc - fall_cyc), 32'(2 + 1 + 20 + 9 * 41 + 1));
    repeat (30) @(negedge clk);
    check("a5_idle_busy", 32'(busy), 32'd0);

    par_en = 1'b1; par_odd = 1'b1;
    send_frame(8'h03, 1'b1, 1'b1, 1'b1, 1'b0);
    check("odd_ok_count", 32'(vcnt), 32'd2);
    check("odd_ok_data", 32'(vdata), 32'h03);
    check("odd_ok_perr", 32'(vperr), 32'd0);
    repeat (30) @(negedge clk);
    send_frame(8'h03, 1'b1, 1'b0, 1'b1, 1'b0);
    check("odd_bad_count", 32'(vcnt), 32'd3);
    check("odd_bad_perr", 32'(vperr), 32'd1);
    check("odd_bad_ferr", 32'(vferr), 32'd0);
    repeat (30) @(negedge clk);
    par_odd = 1'b0;
    send_frame(8'h07, 1'b1, 1'b1, 1'b1, 1'b0);
    check("even_ok_data", 32'(vdata), 32'h07);
    check("even_ok_perr", 32'(vperr), 32'd0);
    par_en = 1'b0;
    repeat (30) @(negedge clk);

    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (200) @(negedge clk);
    check("brk_count", 32'(vcnt), 32'd5);
    check("brk_data", 32'(vdata), 32'h55);
    check("brk_ferr", 32'(vferr), 32'd1);
    check("brk_busy_low", 32'(busy), 32'd1);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    check("brk_busy_rel", 32'(busy), 32'd0);
    repeat (100) @(negedge clk);
    check("brk_no_repeat", 32'(vcnt), 32'd5);

    busy_n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (i == 0) rx = 1'b0;
      if (i == 10) rx = 1'b1;
    end
    check("glitch_busy_cycles", 32'(busy_n), 32'd21);
    check("glitch_no_valid", 32'(vcnt), 32'd5);

    repeat (20) @(negedge clk);
    send_frame(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    check("b2b_first_count", 32'(vcnt), 32'd6);
    check("b2b_first_data", 32'(vdata), 32'h00);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
    check("b2b_second_count", 32'(vcnt), 32'd7);
    check("b2b_second_data", 32'(vdata), 32'hFF);
    check("b2b_perr", 32'(vperr), 32'd0);
    check("b2b_ferr", 32'(vferr), 32'd0);

    repeat (30) @(negedge clk);
    rx = 1'b0;
    repeat (P) @(negedge clk);
    rx = 1'b1;
    repeat (P) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3 * P) @(negedge clk);
    check("rst_mid_no_valid", 32'(vcnt), 32'd7);
`ifdef UART_RX_MAJORITY_EN
    spk = 1'b1;
`else
    spk = 1'b0;
`endif
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, spk);
    check("after_rst_count", 32'(vcnt), 32'd8);
    check("after_rst_data", 32'(vdata), 32'h5A);
    check("after_rst_ferr", 32'(vferr), 32'd0);
    repeat (30) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
